// File: rtl/ei_axi4_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ei_axi4_ctrl_pkg
// Shared types and constants for the AXI4 reset/watchdog controller:
//   - reset-sequencer FSM state encoding (also exported on state_o)
//   - monitored channel indices (bit positions in ch_valid_i/ch_ready_i)
//   - default parameter values
// ----------------------------------------------------------------------------
package ei_axi4_ctrl_pkg;

    typedef enum logic [1:0] {
        ASSERT  = 2'd0,
        SETTLE  = 2'd1,
        RUN     = 2'd2,
        TIMEOUT = 2'd3
    } ei_axi4_rst_state_e;

    localparam int CH_AW = 0;
    localparam int CH_W  = 1;
    localparam int CH_B  = 2;
    localparam int CH_AR = 3;
    localparam int CH_R  = 4;

    localparam int NUM_CH_DEF        = 5;
    localparam int RST_CYCLES_DEF    = 4;
    localparam int SETTLE_CYCLES_DEF = 2;
    localparam int STALL_LIMIT_DEF   = 256;
    localparam int IDLE_TIMEOUT_DEF  = 1024;
    localparam int CNT_W_DEF         = 16;

endpackage

// File: rtl/ei_axi4_chan_watch.sv
// ----------------------------------------------------------------------------
// ei_axi4_chan_watch
// Progress monitor for one valid/ready channel: saturating handshake counter
// plus a consecutive-stall counter with a sticky stall flag.
// Ports:
//   aclk, aresetn   clock, synchronous active-low reset
//   en_i            count/observe only while high
//   clr_i           synchronous clear of all state (wins over en_i)
//   valid_i/ready_i channel handshake signals
//   hs_cnt_o        handshake count, saturates at all-ones
//   stall_o         sticky flag, set once STALL_LIMIT stall cycles are seen
// ----------------------------------------------------------------------------
module ei_axi4_chan_watch #(
    parameter int CNT_W       = 16,
    parameter int STALL_LIMIT = 256
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic             valid_i,
    input  logic             ready_i,
    output logic [CNT_W-1:0] hs_cnt_o,
    output logic             stall_o
);

    localparam int SW = $clog2(STALL_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [SW-1:0]    STALL_LIM = SW'(STALL_LIMIT);

    logic [CNT_W-1:0] hs_cnt_q;
    logic [SW-1:0]    stall_cnt_q;
    logic             stall_q;

    always_ff @(posedge aclk) begin
        if (!aresetn || clr_i) begin
            hs_cnt_q    <= '0;
            stall_cnt_q <= '0;
            stall_q     <= 1'b0;
        end else if (en_i) begin
            if (valid_i && ready_i) begin
                if (hs_cnt_q != CNT_MAX) begin
                    hs_cnt_q <= hs_cnt_q + 1'b1;
                end
                stall_cnt_q <= '0;
            end else if (valid_i) begin
                // Counter parks at the limit; the flag is set on the edge
                // that brings it there so it is visible the following cycle.
                if (stall_cnt_q != STALL_LIM) begin
                    stall_cnt_q <= stall_cnt_q + 1'b1;
                end
                if (stall_cnt_q == STALL_LIM - 1'b1) begin
                    stall_q <= 1'b1;
                end
            end else begin
                stall_cnt_q <= '0;
            end
        end
    end

    assign hs_cnt_o = hs_cnt_q;
    assign stall_o  = stall_q;

endmodule

// File: rtl/ei_axi4_reset_watchdog_ctrl.sv
// ----------------------------------------------------------------------------
// ei_axi4_reset_watchdog_ctrl
// Generates the AXI4 interface reset with a programmable length, then watches
// all channels for progress: per-channel handshake counts, per-channel stall
// flags and a global idle watchdog that parks the FSM in TIMEOUT.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ASSERT  | axi_aresetn_o low, length counter running down
//   SETTLE  | reset released, waiting SETTLE_CYCLES before monitoring
//   RUN     | monitoring enabled, idle watchdog running
//   TIMEOUT | idle limit hit; counters frozen until rst_req_i / aresetn
//
// Ports:
//   aclk, aresetn          clock, synchronous active-low reset
//   rst_req_i, rst_len_i   re-run reset sequence, length (0 -> RST_CYCLES)
//   ch_valid_i, ch_ready_i per-channel VALID/READY (AW, W, B, AR, R)
//   axi_aresetn_o          generated active-low interface reset
//   mon_en_o               high while in RUN
//   hs_cnt_o               packed handshake counts, channel i at [i*CNT_W +: CNT_W]
//   stall_o, timeout_o     sticky stall flags, sticky idle-timeout flag
//   state_o                current FSM state
// ----------------------------------------------------------------------------
module ei_axi4_reset_watchdog_ctrl
    import ei_axi4_ctrl_pkg::*;
#(
    parameter int NUM_CH        = NUM_CH_DEF,
    parameter int RST_CYCLES    = RST_CYCLES_DEF,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter int STALL_LIMIT   = STALL_LIMIT_DEF,
    parameter int IDLE_TIMEOUT  = IDLE_TIMEOUT_DEF,
    parameter int CNT_W         = CNT_W_DEF
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    rst_req_i,
    input  logic [7:0]              rst_len_i,
    input  logic [NUM_CH-1:0]       ch_valid_i,
    input  logic [NUM_CH-1:0]       ch_ready_i,
    output logic                    axi_aresetn_o,
    output logic                    mon_en_o,
    output logic [NUM_CH*CNT_W-1:0] hs_cnt_o,
    output logic [NUM_CH-1:0]       stall_o,
    output logic                    timeout_o,
    output logic [1:0]              state_o
);

    localparam int IW = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [IW-1:0] IDLE_LIM   = IW'(IDLE_TIMEOUT);
    localparam logic [7:0]    RST_LEN    = 8'(RST_CYCLES);
    localparam logic [7:0]    SETTLE_LEN = 8'(SETTLE_CYCLES);

    ei_axi4_rst_state_e state_q;
    logic [7:0]         len_cnt_q;
    logic [IW-1:0]      idle_q;
    logic [IW-1:0]      idle_d;
    logic               timeout_q;
    logic               axi_aresetn_q;
    logic               mon_en_q;
    logic [7:0]         req_len_d;
    logic [NUM_CH-1:0]  hs;
    logic               watch_en;

    assign hs       = ch_valid_i & ch_ready_i;
    assign idle_d   = idle_q + 1'b1;
    assign watch_en = (state_q == RUN) && !rst_req_i;

    // Load value is length-1: the request edge itself is the first low cycle.
    // After aresetn the full RST_CYCLES is loaded since the low phase is
    // counted from the release edge.
    assign req_len_d = (rst_len_i == 8'd0) ? RST_LEN - 8'd1 : rst_len_i - 8'd1;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q       <= ASSERT;
            len_cnt_q     <= RST_LEN;
            idle_q        <= '0;
            timeout_q     <= 1'b0;
            axi_aresetn_q <= 1'b0;
            mon_en_q      <= 1'b0;
        end else if (rst_req_i) begin
            state_q       <= ASSERT;
            len_cnt_q     <= req_len_d;
            idle_q        <= '0;
            timeout_q     <= 1'b0;
            axi_aresetn_q <= 1'b0;
            mon_en_q      <= 1'b0;
        end else begin
            case (state_q)
                ASSERT: begin
                    if (len_cnt_q == 8'd0) begin
                        axi_aresetn_q <= 1'b1;
                        if (SETTLE_CYCLES == 0) begin
                            state_q  <= RUN;
                            mon_en_q <= 1'b1;
                        end else begin
                            state_q   <= SETTLE;
                            len_cnt_q <= SETTLE_LEN - 8'd1;
                        end
                    end else begin
                        len_cnt_q <= len_cnt_q - 8'd1;
                    end
                end
                SETTLE: begin
                    if (len_cnt_q == 8'd0) begin
                        state_q  <= RUN;
                        mon_en_q <= 1'b1;
                    end else begin
                        len_cnt_q <= len_cnt_q - 8'd1;
                    end
                end
                RUN: begin
                    if (|hs) begin
                        idle_q <= '0;
                    end else begin
                        idle_q <= idle_d;
                        if (idle_d == IDLE_LIM) begin
                            timeout_q <= 1'b1;
                            state_q   <= TIMEOUT;
                            mon_en_q  <= 1'b0;
                        end
                    end
                end
                TIMEOUT: begin
                end
                default: begin
                    state_q <= ASSERT;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        ei_axi4_chan_watch #(
            .CNT_W       (CNT_W),
            .STALL_LIMIT (STALL_LIMIT)
        ) u_watch (
            .aclk     (aclk),
            .aresetn  (aresetn),
            .en_i     (watch_en),
            .clr_i    (rst_req_i),
            .valid_i  (ch_valid_i[gi]),
            .ready_i  (ch_ready_i[gi]),
            .hs_cnt_o (hs_cnt_o[gi*CNT_W +: CNT_W]),
            .stall_o  (stall_o[gi])
        );
    end

    assign axi_aresetn_o = axi_aresetn_q;
    assign mon_en_o      = mon_en_q;
    assign timeout_o     = timeout_q;
    assign state_o       = state_q;

endmodule
